// File: rtl/pc_unit_if.sv
// Fetch-stage control/result bundle between the pipeline control and the PC unit.
// The pipeline drives redirect requests; the PC unit returns the current fetch address and RAS status.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;
  logic            exc_i;
  logic            branch_i;
  logic            call_i;
  logic            ret_i;
  logic [XLEN-1:0] target_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus_o;
  logic            ras_empty_o;
  logic            ras_full_o;

  modport master (
    output stall_i, flush_i, flush_pc_i, exc_i, branch_i, call_i, ret_i, target_i,
    input  pc_o, pc_plus_o, ras_empty_o, ras_full_o
  );

  modport slave (
    input  stall_i, flush_i, flush_pc_i, exc_i, branch_i, call_i, ret_i, target_i,
    output pc_o, pc_plus_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised next-PC selection and a circular
// return-address stack that lets returns redirect without waiting for execute.
module pc_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(32'h0000_0080),
  parameter int              INST_BYTES = 4,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  pc_unit_if.slave  bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;

  assign pc_plus   = pc_q + XLEN'(INST_BYTES);
  assign ras_top   = ras_q[ptr_q] & ALIGN_MASK;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

  // NOTE: every signal gets a default before the priority chain so no path leaves it unassigned (no latches).
  always_comb begin
    pc_d      = pc_plus;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;

    if (bus.exc_i) begin
      pc_d = EXC_VEC;
    end else if (bus.flush_i) begin
      pc_d = bus.flush_pc_i & ALIGN_MASK;
    end else if (bus.stall_i) begin
      pc_d = pc_q;
    end else if (bus.ret_i && bus.call_i) begin
      // Return-then-call: swap the top entry in place, stack depth unchanged.
      ras_we = 1'b1;
      if (ras_empty) begin
        cnt_d = CW'(1);
      end else begin
        pc_d = ras_top;
      end
    end else if (bus.ret_i) begin
      if (!ras_empty) begin
        pc_d  = ras_top;
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end else if (bus.call_i) begin
      pc_d      = bus.target_i & ALIGN_MASK;
      ptr_d     = ptr_q + PW'(1);
      ras_waddr = ptr_q + PW'(1);
      ras_we    = 1'b1;
      if (!ras_full) cnt_d = cnt_q + CW'(1);
    end else if (bus.branch_i) begin
      pc_d = bus.target_i & ALIGN_MASK;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the stack storage is deliberately not reset; emptiness is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (ras_we) ras_q[ras_waddr] <= pc_plus;
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_plus_o   = pc_plus;
  assign bus.ras_empty_o = ras_empty;
  assign bus.ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Directed and random stimulus for pc_unit, checked each cycle against a
// queue-based model of the fetch PC and return-address stack.
module tb_pc_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] EXC   = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN(32), .RESET_VEC(32'h0), .EXC_VEC(EXC), .INST_BYTES(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: architectural PC plus a bounded list of return addresses (newest at back).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    bus.pc_o,             m_pc);
    check({tag, ".plus"},  bus.pc_plus_o,        m_pc + 32'd4);
    check({tag, ".empty"}, 32'(bus.ras_empty_o), 32'(m_ras.size() == 0));
    check({tag, ".full"},  32'(bus.ras_full_o),  32'(m_ras.size() == DEPTH));
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_step(input logic st, fl, ex, br, ca, re, input logic [31:0] fpc, tgt);
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (ex)      m_pc = EXC;
    else if (fl) m_pc = {fpc[31:2], 2'b00};
    else if (st) m_pc = m_pc;
    else if (re) begin
      if (m_ras.size() > 0) begin
        m_pc = {m_ras[$][31:2], 2'b00};
        if (ca) m_ras[$] = seq;
        else    void'(m_ras.pop_back());
      end else begin
        m_pc = seq;
        if (ca) m_ras.push_back(seq);
      end
    end else if (ca) begin
      m_ras.push_back(seq);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      m_pc = {tgt[31:2], 2'b00};
    end else if (br) m_pc = {tgt[31:2], 2'b00};
    else             m_pc = seq;
  endtask

  task automatic cycle(input string tag, input logic st, fl, ex, br, ca, re,
                       input logic [31:0] fpc, tgt);
    bus.stall_i = st; bus.flush_i = fl; bus.exc_i = ex; bus.branch_i = br;
    bus.call_i = ca; bus.ret_i = re; bus.flush_pc_i = fpc; bus.target_i = tgt;
    @(posedge clk);
    model_step(st, fl, ex, br, ca, re, fpc, tgt);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic call(input logic [31:0] tgt);
    cycle("call", 0, 0, 0, 0, 1, 0, 32'h0, tgt);
  endtask

  task automatic ret();
    cycle("ret", 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
  endtask

  task automatic flush(input logic [31:0] fpc);
    cycle("flush", 0, 1, 0, 0, 0, 0, fpc, 32'h0);
  endtask

  initial begin
    bus.stall_i = 0; bus.flush_i = 0; bus.exc_i = 0; bus.branch_i = 0;
    bus.call_i = 0; bus.ret_i = 0; bus.flush_pc_i = '0; bus.target_i = '0;
    model_reset();

    // Reset state
    #3;
    check_model("reset");
    @(negedge clk) rst = 0;

    // Free-running sequential fetch
    idle("seq0"); idle("seq1"); idle("seq2");
    check("seq_pc12", bus.pc_o, 32'hC);
    idle("seq3");

    // Call / return round trip from 0x10
    call(32'h100);
    check("call_empty", 32'(bus.ras_empty_o), 32'd0);
    idle("body0"); idle("body1");
    ret();
    check("ret_pc", bus.pc_o, 32'h14);
    check("ret_empty", 32'(bus.ras_empty_o), 32'd1);

    // Nested calls overflow the stack, then unwind
    flush(32'h0);
    call(32'h100); call(32'h200); call(32'h300); call(32'h400);
    check("nest_full", 32'(bus.ras_full_o), 32'd1);
    call(32'h500);
    check("nest_full_ovf", 32'(bus.ras_full_o), 32'd1);
    ret(); check("unwind0", bus.pc_o, 32'h404);
    ret(); check("unwind1", bus.pc_o, 32'h304);
    ret(); check("unwind2", bus.pc_o, 32'h204);
    ret(); check("unwind3", bus.pc_o, 32'h104);
    ret(); check("unwind_empty", bus.pc_o, 32'h108);

    // Stall vs. redirect priority
    cycle("stall_br0", 1, 0, 0, 1, 0, 0, 32'h0, 32'h200);
    cycle("stall_br1", 1, 0, 0, 1, 0, 0, 32'h0, 32'h200);
    check("stall_hold", bus.pc_o, 32'h108);
    cycle("stall_flush", 1, 1, 0, 0, 0, 0, 32'h3C, 32'h0);
    check("stall_flush_pc", bus.pc_o, 32'h3C);
    cycle("exc_flush", 0, 1, 1, 0, 0, 0, 32'h3C, 32'h0);
    check("exc_pc", bus.pc_o, EXC);

    // Target alignment and address wrap
    cycle("branch_unaligned", 0, 0, 0, 1, 0, 0, 32'h0, 32'h107);
    check("branch_aligned", bus.pc_o, 32'h104);
    flush(32'hFFFF_FFF8);
    idle("wrap0");
    check("wrap_plus", bus.pc_plus_o, 32'h0);
    idle("wrap1");
    check("wrap_pc", bus.pc_o, 32'h0);

    // Simultaneous return and call, on empty and non-empty stacks
    cycle("retcall_empty", 0, 0, 0, 0, 1, 1, 32'h0, 32'h0);
    call(32'h600);
    cycle("retcall_full", 0, 0, 0, 1, 1, 1, 32'h0, 32'h900);
    ret(); ret(); ret();

    // Asynchronous reset mid-cycle with two entries stacked
    call(32'h700); call(32'h800);
    #2 rst = 1;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk) rst = 0;
    ret();
    check("post_rst_ret", bus.pc_o, 32'h4);

    // Random control mix
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage; successor to the fixed 32-bit stallable PC register.
- Holds the architectural fetch PC and selects the next PC from exception, flush, return, branch/call and sequential sources.
- Contains a small circular return-address stack (RAS) so the fetch stage can redirect on returns without waiting for execute.

Parameters:
XLEN, 32, PC and address width in bits (>= 8).
RESET_VEC, 0, value loaded into PC on reset.
EXC_VEC, 32'h0000_0080, exception handler address. Truncated to XLEN.
INST_BYTES, 4, sequential increment. Power of 2, 1..8.
RAS_DEPTH, 4, return-address stack entries. Power of 2, 2..16.

Ports:
clk_i  input  1  clock; all state updates on posedge
rst_i  input  1  reset, asynchronous, active-high
stall_i  input  1  hold PC and RAS for this cycle
flush_i  input  1  redirect PC to flush_pc_i (mispredict recovery)
flush_pc_i  input  XLEN  flush target
exc_i  input  1  redirect PC to EXC_VEC
branch_i  input  1  taken branch/jump to target_i
call_i  input  1  call: jump to target_i and push return address
ret_i  input  1  return: jump to popped RAS entry
target_i  input  XLEN  branch/call target
pc_o  output  XLEN  current PC (registered)
pc_plus_o  output  XLEN  pc_o + INST_BYTES (combinational)
ras_empty_o  output  1  RAS count == 0 (registered state)
ras_full_o  output  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (async, any time including mid-operation):
  - pc_o = RESET_VEC.
  - RAS pointer = 0, count = 0, so ras_empty_o = 1 and ras_full_o = 0.
  - RAS entry contents are don't-care.
- pc_plus_o = (pc_o + INST_BYTES) mod 2^XLEN. Wrap from all-ones is legal and silent.
- Alignment: all loaded targets (flush_pc_i, target_i, popped RAS value) have their low log2(INST_BYTES) bits forced to 0 before loading. RESET_VEC and EXC_VEC are loaded unmodified.
- Next-PC priority, evaluated each posedge, highest first:
  1. exc_i: PC <= EXC_VEC. RAS unchanged.
  2. flush_i: PC <= flush_pc_i. RAS unchanged.
  3. stall_i: PC and RAS hold.
  4. ret_i && call_i: PC <= RAS top, or pc_plus_o if empty. Top entry is overwritten with pc_plus_o. Count unchanged, except empty -> 1 (entry written at pointer).
  5. ret_i: if count > 0, PC <= top and pop (pointer-1 mod RAS_DEPTH, count-1). If empty, PC <= pc_plus_o and RAS unchanged.
  6. call_i: PC <= target_i and push pc_plus_o (pointer+1 mod RAS_DEPTH, write, count = min(count+1, RAS_DEPTH)).
     - Push when full overwrites the oldest entry (circular). ras_full_o stays 1.
  7. branch_i: PC <= target_i.
  8. Otherwise: PC <= pc_plus_o.
- exc_i and flush_i override stall_i; a stall never blocks a redirect.
- branch_i is ignored when call_i or ret_i is asserted.
- Latency: redirects take effect on pc_o one cycle after the sampling edge. No bubbles are generated internally.
- Top-of-stack read is combinational from the current pointer. A pop followed by a push in the next cycle reuses the freed slot.
- No X propagation: control inputs are assumed 0/1. Unknown control values need not be handled.

Test Plan:
- Reset, then 3 free-running cycles with all controls 0 (INST_BYTES=4) -> pc_o = 0, 4, 8, 12; ras_empty_o = 1.
- At pc=0x10: call_i with target_i=0x100, then 2 sequential cycles, then ret_i -> pc_o = 0x100, 0x104, 0x108, 0x14; ras_empty_o goes 0 then back to 1.
- 5 nested calls with RAS_DEPTH=4 from pcs 0x0, 0x100, 0x200, 0x300, 0x400 (targets 0x100..0x500), then 5 rets -> returns 0x404, 0x304, 0x204, 0x104. The 5th ret sees empty and goes sequential. ras_full_o = 1 after the 4th push.
- stall_i with branch_i asserted for 2 cycles -> pc_o frozen. Then stall_i with flush_i (flush_pc_i=0x3C) -> pc_o = 0x3C next cycle. exc_i with flush_i -> pc_o = EXC_VEC.
- target_i=0x107 on a branch -> pc_o = 0x104. Run near 0xFFFF_FFFC sequentially -> pc_o wraps to 0x0.
- Assert rst_i asynchronously mid-cycle with count=2 -> pc_o = RESET_VEC immediately; ras_empty_o = 1. A ret after reset release goes sequential.
